des_decrypt_iter: RTL and testbench
===================================

DES_DECRYPT_ITER -- requirements
Module: des_decrypt_iter

Interface
REQ-001 The module SHALL have ports: clk input 1, the single clock; all state changes on its rising edge.
REQ-002 The module SHALL have port rst_n input 1, asynchronous active-low reset.
REQ-003 The module SHALL have port in_valid input 1, meaning ciphertext/key offered.
REQ-004 The module SHALL have port in_ready output 1, meaning the core can accept a block.
REQ-005 The module SHALL have port ciphertext input [1:64], the DES block; bit 1 is the MSB.
REQ-006 The module SHALL have port key input [1:64], the DES key with parity bits 8,16,...,64.
REQ-007 The module SHALL have port out_valid output 1, meaning the result is held.
REQ-008 The module SHALL have port out_ready input 1, meaning the consumer takes the result.
REQ-009 The module SHALL have port plaintext output [1:64], the decrypted block.
REQ-010 The module SHALL have port key_err output 1, meaning a parity fault; it exists only with DES_KEY_PARITY_CHECK_EN.

Function
REQ-011 FSM states SHALL be IDLE, ROUND and DONE.
REQ-012 in_ready SHALL be 1 in IDLE only; acceptance SHALL occur on an edge where in_valid && in_ready.
REQ-013 On acceptance: L/R SHALL load IP(ciphertext); C/D SHALL load PC1(key); round counter SHALL be 0; state SHALL become ROUND.
REQ-014 Subkeys SHALL be applied in reverse order K16..K1: round 0 uses PC2(C,D) unrotated; after round i, C and D SHALL each rotate right by shift[16-i] (schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1).
REQ-015 Each ROUND cycle SHALL perform one Feistel round: L<=R, R<=L^f(R,K); counter increments modulo 16.
REQ-016 After round 15 the L/R swap SHALL be undone, plaintext SHALL be registered as FP(R16,L16), and state SHALL become DONE.
REQ-017 out_valid SHALL rise exactly 17 cycles after the acceptance edge.
REQ-018 In DONE, out_valid=1 and plaintext SHALL stay stable until out_ready=1; on that edge, state SHALL become IDLE and out_valid SHALL become 0.
REQ-019 No new block SHALL be accepted in the same cycle the result is consumed; in_ready rises one cycle after the handoff.
REQ-020 ciphertext and key changes after acceptance SHALL NOT affect the result in flight.

Reset
REQ-021 While rst_n=0: state IDLE, in_ready=1 after release, out_valid=0, plaintext=64'h0, key_err=0, counter=0.
REQ-022 Reset asserted mid-ROUND or DONE SHALL abort immediately; the partial result SHALL be discarded.

Configuration
REQ-023 With DES_KEY_PARITY_CHECK_EN defined, every key byte SHALL have odd parity checked at acceptance.
REQ-024 On a parity failure, the core SHALL skip ROUND and enter DONE next cycle with plaintext=64'h0 and key_err=1; key_err SHALL clear on handoff.
REQ-025 Without DES_KEY_PARITY_CHECK_EN, the key_err port SHALL be absent, parity bits SHALL be ignored, and latency SHALL always be 17.

Structure
REQ-026 Package des_pkg SHALL hold the IP, FP, E, P, PC1, PC2 and S-box tables, the shift schedule, and the state enum.
REQ-027 Sub-module des_round SHALL be the combinational f-function plus XOR (inputs L,R,K48; outputs L',R'), instantiated once.

Verification
REQ-028 Key 133457799BBCDFF1, ciphertext 85E813540F0AB405 -> plaintext 0123456789ABCDEF, out_valid at cycle 17.
REQ-029 Key 0E329232EA6D0D73, ciphertext 0000000000000000 -> plaintext 8787878787878787.
REQ-030 Hold out_ready=0 for 5 cycles after out_valid -> plaintext stable, in_ready=0; release -> in_ready=1 next cycle.
REQ-031 Assert rst_n=0 at round 8 -> out_valid=0 immediately; a following block decrypts correctly.
REQ-032 With DES_KEY_PARITY_CHECK_EN, key 133457799BBCDFF0 -> out_valid 1 cycle after accept, key_err=1, plaintext=0.
REQ-033 Round-trip with the des encryptor on 1000 random blocks under key 0E329232EA6D0D73 -> every output equals the original plaintext.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg: DES permutation tables, S-boxes, shift schedule, FSM states.
// Table entries number bits from 1 = MSB of the vector they index.
package des_pkg;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

   localparam int FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

   localparam int E_T [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   localparam int SHIFT_T [16] = '{
      1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Row-major: entry = row * 16 + column.
   localparam int SBOX_T [8][64] = '{
      '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
      '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
      '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
      '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
      '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
      '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
      '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
      '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

   function automatic logic [63:0] ip_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++)
         y[6'(63 - i)] = x[6'(64 - IP_T[i])];
      return y;
   endfunction

   function automatic logic [63:0] fp_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++)
         y[6'(63 - i)] = x[6'(64 - FP_T[i])];
      return y;
   endfunction

   function automatic logic [47:0] e_perm(input logic [31:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++)
         y[6'(47 - i)] = x[5'(32 - E_T[i])];
      return y;
   endfunction

   function automatic logic [31:0] p_perm(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int i = 0; i < 32; i++)
         y[5'(31 - i)] = x[5'(32 - P_T[i])];
      return y;
   endfunction

   function automatic logic [55:0] pc1_perm(input logic [63:0] x);
      logic [55:0] y;
      y = '0;
      for (int i = 0; i < 56; i++)
         y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
      return y;
   endfunction

   function automatic logic [47:0] pc2_perm(input logic [55:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++)
         y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
      return y;
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x,
                                          input logic two);
      return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   function automatic logic key_parity_ok(input logic [63:0] k);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 8; i++)
         ok = ok & (^(8'(k >> (8 * i))));
      return ok;
   endfunction

endpackage

// File: rtl/des_round.sv
// des_round: one combinational Feistel round, L' = R, R' = L ^ f(R, K).
// f = P(S(E(R) ^ K)); eight S-boxes addressed by {b1,b6} row, b2..b5 col.
module des_round
   import des_pkg::*;
(
   input  logic [31:0] i_l,
   input  logic [31:0] i_r,
   input  logic [47:0] i_k48,
   output logic [31:0] o_l,
   output logic [31:0] o_r
);

   logic [47:0] w_x;
   logic [31:0] w_s;

   assign w_x = e_perm(i_r) ^ i_k48;

   for (genvar s = 0; s < 8; s++) begin : g_sbox
      logic [5:0] w_b;
      assign w_b = w_x[47-6*s -: 6];
      assign w_s[31-4*s -: 4] =
         4'(SBOX_T[s][{w_b[5], w_b[0], w_b[4:1]}]);
   end

   assign o_l = i_r;
   assign o_r = i_l ^ p_perm(w_s);

endmodule

// File: rtl/des_decrypt_iter.sv
// des_decrypt_iter: iterative DES decryptor, one round per clock.
// Define DES_KEY_PARITY_CHECK_EN to add key parity checking and key_err.
module des_decrypt_iter
   import des_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] ciphertext,
   input  logic [63:0] key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] plaintext
`ifdef DES_KEY_PARITY_CHECK_EN
   ,
   output logic        key_err
`endif
);

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_l;
   logic [31:0] r_r;
   logic [31:0] w_lo;
   logic [31:0] w_ro;
   logic [27:0] r_c;
   logic [27:0] r_d;
   logic [3:0]  r_cnt;
   logic        r_fin;
   logic [63:0] r_pt;
   logic [47:0] w_k;
   logic        w_two;
   logic        w_acc;
   logic        w_perr;

   assign w_acc     = in_valid && in_ready;
   assign w_k       = pc2_perm({r_c, r_d});
   assign w_two     = (SHIFT_T[4'd15 - r_cnt] == 2);
   assign plaintext = r_pt;

`ifdef DES_KEY_PARITY_CHECK_EN
   logic r_kerr;

   assign w_perr  = ~key_parity_ok(key);
   assign key_err = r_kerr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_kerr <= 1'b0;
      else if (w_acc)
         r_kerr <= w_perr;
      else if (out_valid && out_ready)
         r_kerr <= 1'b0;
   end
`else
   assign w_perr = 1'b0;
`endif

   des_round u_round (
      .i_l   (r_l),
      .i_r   (r_r),
      .i_k48 (w_k),
      .o_l   (w_lo),
      .o_r   (w_ro)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = ROUND;
         end
         ROUND: begin
            if (r_fin) w_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // r_fin marks the extra cycle that registers FP(R16,L16).
   // A bad-parity key goes straight to it, skipping all rounds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_l   <= '0;
         r_r   <= '0;
         r_c   <= '0;
         r_d   <= '0;
         r_cnt <= '0;
         r_fin <= 1'b0;
         r_pt  <= '0;
      end else if (w_acc) begin
         {r_l, r_r} <= ip_perm(ciphertext);
         {r_c, r_d} <= pc1_perm(key);
         r_cnt      <= '0;
         r_fin      <= w_perr;
      end else if (r_state == ROUND) begin
         if (r_fin) begin
            r_fin <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
            r_pt  <= r_kerr ? '0 : fp_perm({r_r, r_l});
`else
            r_pt  <= fp_perm({r_r, r_l});
`endif
         end else begin
            r_l   <= w_lo;
            r_r   <= w_ro;
            r_c   <= rotr28(r_c, w_two);
            r_d   <= rotr28(r_d, w_two);
            r_cnt <= r_cnt + 4'd1;
            r_fin <= (r_cnt == 4'd15);
         end
      end
   end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// tb_des_decrypt_iter: randomized bench against a behavioural DES model.
// Known answers, handshake hold, mid-run reset, parity and round trips.
module tb_des_decrypt_iter;
   import des_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [63:0] ciphertext = '0;
   logic [63:0] key = '0;
   logic [63:0] plaintext;
`ifdef DES_KEY_PARITY_CHECK_EN
   logic        key_err;
`endif

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [47:0] mk [16];

   always #5 clk = ~clk;

   des_decrypt_iter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ciphertext (ciphertext),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
`ifdef DES_KEY_PARITY_CHECK_EN
      .key_err    (key_err),
`endif
      .plaintext  (plaintext)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // ---- behavioural DES model ----
   function automatic int tab(input int which, input int i);
      case (which)
         0: return IP_T[i];
         1: return FP_T[i];
         2: return E_T[i];
         3: return P_T[i];
         4: return PC1_T[i];
         5: return PC2_T[i];
         default: return 0;
      endcase
   endfunction

   // Output bit i (MSB first) is input bit tab(which,i), numbered from MSB.
   function automatic logic [63:0] perm(input logic [63:0] x, input int nin,
                                        input int nout, input int which);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < nout; i++)
         y = (y << 1) | ((x >> (nin - tab(which, i))) & 64'd1);
      return y;
   endfunction

   task automatic make_keys(input logic [63:0] k);
      logic [55:0] cd;
      logic [27:0] c;
      logic [27:0] d;
      cd = 56'(perm(k, 64, 56, 4));
      c  = cd[55:28];
      d  = cd[27:0];
      for (int r = 0; r < 16; r++) begin
         for (int s = 0; s < SHIFT_T[r]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         mk[r] = 48'(perm({8'h0, c, d}, 56, 48, 5));
      end
   endtask

   function automatic logic [31:0] f_fn(input logic [31:0] r,
                                        input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s;
      int six;
      int row;
      int col;
      x = 48'(perm({32'h0, r}, 32, 48, 2)) ^ k;
      s = '0;
      for (int b = 0; b < 8; b++) begin
         six = int'((x >> (42 - 6 * b)) & 48'h3F);
         row = ((six >> 4) & 2) | (six & 1);
         col = (six >> 1) & 15;
         s   = (s << 4) | 32'(SBOX_T[b][row * 16 + col]);
      end
      return 32'(perm({32'h0, s}, 32, 32, 3));
   endfunction

   function automatic logic [63:0] des(input logic [63:0] blk, input bit dec);
      logic [63:0] t;
      logic [31:0] l;
      logic [31:0] r;
      logic [31:0] n;
      t = perm(blk, 64, 64, 0);
      l = t[63:32];
      r = t[31:0];
      for (int i = 0; i < 16; i++) begin
         n = l ^ f_fn(r, mk[dec ? 15 - i : i]);
         l = r;
         r = n;
      end
      return perm({r, l}, 64, 64, 1);
   endfunction

   function automatic logic [63:0] odd_par(input logic [63:0] k);
      logic [63:0] y;
      logic [7:0]  b;
      y = '0;
      for (int i = 0; i < 8; i++) begin
         b    = 8'(k >> (56 - 8 * i));
         b[0] = ~^b[7:1];
         y    = (y << 8) | 64'(b);
      end
      return y;
   endfunction

   // ---- stimulus helpers (called at a falling edge) ----
   task automatic send(input logic [63:0] ct, input logic [63:0] k,
                       output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      check("in_ready_wait", in_ready, 1'b1);
      in_valid   = 1'b1;
      ciphertext = ct;
      key        = k;
      @(negedge clk);
      in_valid   = 1'b0;
      ciphertext = {$urandom, $urandom};
      key        = {$urandom, $urandom};
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic take(input int hold, input logic [63:0] exp_pt);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1'b1);
         check("hold_pt", plaintext, exp_pt);
         check("hold_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      #1;
      check("handoff_in_ready", in_ready, 1'b0);
      @(negedge clk);
      out_ready = 1'b0;
      check("post_out_valid", out_valid, 1'b0);
      check("post_in_ready", in_ready, 1'b1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [63:0] p;
      logic [63:0] k;
      logic [63:0] ct;

      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_plaintext", plaintext, 64'h0);
      check("rst_in_ready", in_ready, 1'b1);
`ifdef DES_KEY_PARITY_CHECK_EN
      check("rst_key_err", key_err, 1'b0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      send(64'h85E813540F0AB405, 64'h133457799BBCDFF1, lat);
      check("kat1_latency", lat, 17);
      check("kat1_pt", plaintext, 64'h0123456789ABCDEF);
      take(5, 64'h0123456789ABCDEF);

      send(64'h0, 64'h0E329232EA6D0D73, lat);
      check("kat2_latency", lat, 17);
      check("kat2_pt", plaintext, 64'h8787878787878787);
      take(1, 64'h8787878787878787);

      // Abort at round 8.
      in_valid   = 1'b1;
      ciphertext = 64'h0;
      key        = 64'h0E329232EA6D0D73;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_in_ready", in_ready, 1'b0);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_in_ready", in_ready, 1'b1);
      check("abort_pt", plaintext, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_idle_valid", out_valid, 1'b0);
      send(64'h85E813540F0AB405, 64'h133457799BBCDFF1, lat);
      check("after_abort_latency", lat, 17);
      check("after_abort_pt", plaintext, 64'h0123456789ABCDEF);

      // Abort while the result is held.
      rst_n = 1'b0;
      #1;
      check("done_abort_valid", out_valid, 1'b0);
      check("done_abort_pt", plaintext, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef DES_KEY_PARITY_CHECK_EN
      send(64'h85E813540F0AB405, 64'h133457799BBCDFF0, lat);
      check("parity_latency", lat, 1);
      check("parity_key_err", key_err, 1'b1);
      check("parity_pt", plaintext, 64'h0);
      take(0, 64'h0);
      check("parity_err_clear", key_err, 1'b0);
`else
      send(64'h85E813540F0AB405, 64'h133457799BBCDFF0, lat);
      check("parity_ignored_latency", lat, 17);
      check("parity_ignored_pt", plaintext, 64'h0123456789ABCDEF);
      take(0, 64'h0123456789ABCDEF);
`endif

      k = 64'h0E329232EA6D0D73;
      make_keys(k);
      for (int i = 0; i < 1000; i++) begin
         p  = {$urandom, $urandom};
         ct = des(p, 1'b0);
         send(ct, k, lat);
         check("rt_latency", lat, 17);
         check("rt_pt", plaintext, p);
         take(int'($urandom_range(0, 2)), p);
      end

      for (int i = 0; i < 40; i++) begin
         k = odd_par({$urandom, $urandom});
         make_keys(k);
         p  = {$urandom, $urandom};
         ct = des(p, 1'b0);
         send(ct, k, lat);
         check("rk_latency", lat, 17);
         check("rk_pt", plaintext, p);
         take(0, p);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
